// File: rtl/serial_master.sv
// serial_master: clocked serial master with a tick divider and LEAD/SHIFT/TRAIL chip-select framing.
// Optional SERIAL_MASTER_LOOPBACK_EN: samples the internal out_serial value instead of in_serial.
module serial_master #(
   parameter int   MAIN_CLK_HZ          = 50_000_000,
   parameter int   SERIAL_CLK_HZ        = 10_000,
   parameter int   BITS                 = 8,
   parameter int   NUM_SLAVES           = 4,
   parameter logic CPOL                 = 1'b1,
   parameter logic CPHA                 = 1'b1,
   parameter logic LOWBIT_FIRST         = 1'b1,
   parameter logic SERIAL_DATA_INACTIVE = 1'b1,
   localparam int  SW                   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_enable,
   input  logic [SW-1:0]         in_slave_sel,
   input  logic [BITS-1:0]       in_parallel,
   input  logic                  in_serial,
   output logic                  out_serial,
   output logic                  out_clk,
   output logic [NUM_SLAVES-1:0] out_cs_n,
   output logic                  out_ready,
   output logic                  out_next_word,
   output logic                  out_word_finished,
   output logic [BITS-1:0]       out_parallel
);
   localparam int HALF = MAIN_CLK_HZ / (2 * SERIAL_CLK_HZ);
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EW   = $clog2(2 * BITS + 1);
   localparam int IW   = $clog2(BITS);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   state_t                state_q, state_d;
   logic [DW-1:0]         div_q, div_d;
   logic [EW-1:0]         edge_q, edge_d, pos_raw, cnt;
   logic [BITS-1:0]       tx_q, tx_d, rx_q, rx_d, par_q, par_d;
   logic [NUM_SLAVES-1:0] cs_q, cs_d, cs_sel;
   logic                  clk_q, clk_d, fin_q, fin_d;
   logic                  tick, last, samp, smp_bit;
   logic [IW-1:0]         idx;

   assign tick    = (state_q != IDLE) && (div_q == DW'(HALF - 1));
   assign last    = edge_q == EW'(2 * BITS - 1);
   assign samp    = edge_q[0] == CPHA;
   // edge_q counts completed edges; the active bit advances only on non-sample edges
   assign pos_raw = (CPHA && edge_q != '0) ? edge_q - 1'b1 : edge_q;
   assign cnt     = ((pos_raw >> 1) > EW'(BITS - 1)) ? EW'(BITS - 1) : (pos_raw >> 1);
   assign idx     = IW'(LOWBIT_FIRST ? cnt : EW'(BITS - 1) - cnt);

   assign out_serial        = (state_q == IDLE) ? SERIAL_DATA_INACTIVE : tx_q[idx];
   assign out_clk           = clk_q;
   assign out_cs_n          = cs_q;
   assign out_ready         = state_q == IDLE;
   assign out_word_finished = fin_q;
   assign out_parallel      = par_q;

`ifdef SERIAL_MASTER_LOOPBACK_EN
   assign smp_bit = out_serial;
`else
   assign smp_bit = in_serial;
`endif

   always_comb begin
      cs_sel = '1;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (in_slave_sel == SW'(i)) cs_sel[i] = 1'b0;
   end

   always_comb begin
      state_d       = state_q;
      div_d         = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
      edge_d        = edge_q;
      tx_d          = tx_q;
      rx_d          = rx_q;
      par_d         = par_q;
      cs_d          = cs_q;
      clk_d         = CPOL;
      fin_d         = 1'b0;
      out_next_word = 1'b0;
      case (state_q)
         IDLE: if (in_enable) begin
            tx_d    = in_parallel;
            cs_d    = cs_sel;
            edge_d  = '0;
            state_d = LEAD;
         end
         LEAD: if (tick) state_d = SHIFT;
         SHIFT: begin
            clk_d = clk_q;
            if (tick) begin
               clk_d  = ~clk_q;
               edge_d = edge_q + 1'b1;
               if (samp) rx_d[idx] = smp_bit;
               if (last) begin
                  par_d  = rx_d;
                  fin_d  = 1'b1;
                  edge_d = '0;
                  if (in_enable) begin
                     tx_d          = in_parallel;
                     out_next_word = 1'b1;
                  end else begin
                     state_d = TRAIL;
                  end
               end
            end
         end
         TRAIL: if (tick) begin
            cs_d    = '1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         par_q   <= '0;
         cs_q    <= '1;
         clk_q   <= CPOL;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         par_q   <= par_d;
         cs_q    <= cs_d;
         clk_q   <= clk_d;
         fin_q   <= fin_d;
      end
   end
endmodule

// File: tb/tb_serial_master.sv
// tb_serial_master: directed vectors for two serial_master configurations at HALF=2.
module tb_serial_master;
`ifdef SERIAL_MASTER_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic en0 = 1'b0, si0 = 1'b0;
   logic [1:0] sel0 = '0;
   logic [7:0] par0 = '0, pout0;
   logic ser0, oclk0, rdy0, nw0, fin0;
   logic [3:0] cs0;
   logic en1 = 1'b0, si1 = 1'b1;
   logic [2:0] sel1 = '0;
   logic [7:0] par1 = '0, pout1;
   logic ser1, oclk1, rdy1, nw1, fin1;
   logic [4:0] cs1;

   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   serial_master #(.MAIN_CLK_HZ(4), .SERIAL_CLK_HZ(1)) u0 (
      .in_clk(clk), .in_rst(rst), .in_enable(en0), .in_slave_sel(sel0), .in_parallel(par0),
      .in_serial(si0), .out_serial(ser0), .out_clk(oclk0), .out_cs_n(cs0), .out_ready(rdy0),
      .out_next_word(nw0), .out_word_finished(fin0), .out_parallel(pout0));

   serial_master #(.MAIN_CLK_HZ(4), .SERIAL_CLK_HZ(1), .NUM_SLAVES(5), .CPOL(1'b0), .CPHA(1'b0),
                   .LOWBIT_FIRST(1'b0)) u1 (
      .in_clk(clk), .in_rst(rst), .in_enable(en1), .in_slave_sel(sel1), .in_parallel(par1),
      .in_serial(si1), .out_serial(ser1), .out_clk(oclk1), .out_cs_n(cs1), .out_ready(rdy1),
      .out_next_word(nw1), .out_word_finished(fin1), .out_parallel(pout1));

   // u0 observer and slave: drives miso bit k until the k-th rising out_clk
   int rise_c0 = 0, fin_c0 = 0, nw_c0 = 0, cserr0 = 0, gaperr0 = 0, ohe0 = 0, rcnt0 = 0, since0 = 0;
   logic prev_clk0 = 1'b1, prev_ser0 = 1'b1, seen0 = 1'b0;
   logic [31:0] cap0 = '0;
   logic [7:0] miso0 = '0;
   logic [3:0] exp_cs0 = 4'hF;
   always @(negedge clk) begin
      if (fin0) fin_c0++;
      if (nw0) nw_c0++;
      if (!rdy0 && cs0 != exp_cs0) cserr0++;
      if ($countones(~cs0) > 1) ohe0++;
      if (!prev_clk0 && oclk0) begin
         rise_c0++;
         cap0 = {cap0[30:0], prev_ser0};
         if (seen0 && since0 != 3) gaperr0++;
         seen0 = 1'b1;
         since0 = 0;
         rcnt0++;
      end else since0++;
      if (fin0 || rdy0) rcnt0 = 0;
      if (rdy0) seen0 = 1'b0;
      si0 = miso0[rcnt0 % 8];
      prev_clk0 = oclk0;
      prev_ser0 = ser0;
   end

   int rise_c1 = 0, fin_c1 = 0, cserr1 = 0;
   logic prev_clk1 = 1'b0, prev_ser1 = 1'b1;
   logic [31:0] cap1 = '0;
   logic [4:0] exp_cs1 = 5'h1F;
   always @(negedge clk) begin
      if (fin1) fin_c1++;
      if (!rdy1 && cs1 != exp_cs1) cserr1++;
      if (!prev_clk1 && oclk1) begin
         rise_c1++;
         cap1 = {cap1[30:0], prev_ser1};
      end
      prev_clk1 = oclk1;
      prev_ser1 = ser1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic burst0(input logic [7:0] w1, input logic [7:0] w2, input logic [1:0] sel,
                         input logic [7:0] m, input logic [3:0] ecs, input int nwords);
      exp_cs0 = ecs;
      miso0 = m;
      @(negedge clk);
      par0 = w1; sel0 = sel; en0 = 1'b1;
      @(negedge clk);
      sel0 = sel + 2'd1;
      par0 = w2;
      if (nwords == 1) en0 = 1'b0;
      else begin
         for (int k = 0; k < 200 && !nw0; k++) @(negedge clk);
         chk("next_word_seen", {31'd0, nw0}, 32'd1);
         @(negedge clk);
         en0 = 1'b0;
      end
      for (int k = 0; k < 300 && !rdy0; k++) @(negedge clk);
      chk("burst0_done", {31'd0, rdy0}, 32'd1);
   endtask

   task automatic word1(input logic [7:0] w, input logic [2:0] sel, input logic [4:0] ecs);
      exp_cs1 = ecs;
      @(negedge clk);
      par1 = w; sel1 = sel; en1 = 1'b1;
      @(negedge clk);
      en1 = 1'b0;
      chk("u1_lead_first_bit", {31'd0, ser1}, {31'd0, w[7]});
      chk("u1_lead_clk_idle", {31'd0, oclk1}, 32'd0);
      for (int k = 0; k < 300 && !rdy1; k++) @(negedge clk);
      chk("u1_done", {31'd0, rdy1}, 32'd1);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [1:0] sel;
      logic [7:0] miso;
      logic [3:0] cs;
      logic [7:0] cap;
   } vec_t;
   vec_t tbl[4];

   initial begin
      int b_rise, b_fin, b_nw, b_cs, b_gap, b_cs1;
      tbl[0] = '{8'hA5, 2'd2, 8'h3C, 4'b1011, 8'hA5};
      tbl[1] = '{8'h0F, 2'd0, 8'hF0, 4'b1110, 8'hF0};
      tbl[2] = '{8'hFF, 2'd3, 8'h00, 4'b0111, 8'hFF};
      tbl[3] = '{8'h5A, 2'd1, 8'h81, 4'b1101, 8'h5A};

      repeat (3) @(negedge clk);
      chk("rst_cs0", {28'd0, cs0}, 32'hF);
      chk("rst_clk0", {31'd0, oclk0}, 32'd1);
      chk("rst_ser0", {31'd0, ser0}, 32'd1);
      chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
      chk("rst_par0", {24'd0, pout0}, 32'd0);
      chk("rst_pulses0", {30'd0, nw0, fin0}, 32'd0);
      chk("rst_cs1", {27'd0, cs1}, 32'h1F);
      chk("rst_clk1", {31'd0, oclk1}, 32'd0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         b_rise = rise_c0; b_fin = fin_c0; b_nw = nw_c0; b_cs = cserr0;
         burst0(tbl[i].tx, ~tbl[i].tx, tbl[i].sel, tbl[i].miso, tbl[i].cs, 1);
         chk("vec_cs_held", cserr0 - b_cs, 0);
         chk("vec_clk_periods", rise_c0 - b_rise, 8);
         chk("vec_finished", fin_c0 - b_fin, 1);
         chk("vec_no_next_word", nw_c0 - b_nw, 0);
         chk("vec_tx_bits", {24'd0, cap0[7:0]}, {24'd0, tbl[i].cap});
         chk("vec_rx_word", {24'd0, pout0}, {24'd0, LB ? tbl[i].tx : tbl[i].miso});
         chk("vec_idle_lines", {27'd0, ser0, oclk0, cs0 == 4'hF}, 32'h7);
      end

      b_rise = rise_c0; b_fin = fin_c0; b_nw = nw_c0; b_cs = cserr0; b_gap = gaperr0;
      burst0(8'h01, 8'h80, 2'd2, 8'h3C, 4'b1011, 2);
      chk("burst_next_word", nw_c0 - b_nw, 1);
      chk("burst_clk_periods", rise_c0 - b_rise, 16);
      chk("burst_clk_gap", gaperr0 - b_gap, 0);
      chk("burst_cs_no_gap", cserr0 - b_cs, 0);
      chk("burst_finished", fin_c0 - b_fin, 2);
      chk("burst_tx_bits", {16'd0, cap0[15:0]}, 32'h8001);
      chk("burst_rx_word", {24'd0, pout0}, {24'd0, LB ? 8'h80 : 8'h3C});

      b_fin = fin_c0;
      exp_cs0 = 4'b1110; miso0 = 8'h00;
      @(negedge clk);
      par0 = 8'hC3; sel0 = 2'd0; en0 = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_word_busy", {31'd0, rdy0}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_cs0", {28'd0, cs0}, 32'hF);
      chk("mrst_clk0", {31'd0, oclk0}, 32'd1);
      chk("mrst_ser0", {31'd0, ser0}, 32'd1);
      chk("mrst_rdy0", {31'd0, rdy0}, 32'd1);
      chk("mrst_par0", {24'd0, pout0}, 32'd0);
      @(negedge clk);
      chk("mrst_priority", {31'd0, rdy0}, 32'd1);
      @(negedge clk);
      rst = 1'b0; en0 = 1'b0;
      repeat (60) @(negedge clk);
      chk("mrst_no_finish", fin_c0 - b_fin, 0);
      chk("mrst_idle", {31'd0, rdy0}, 32'd1);

      b_rise = rise_c1; b_fin = fin_c1; b_cs1 = cserr1;
      word1(8'hC3, 3'd1, 5'b11101);
      chk("u1_sampled_bits", {24'd0, cap1[7:0]}, 32'hC3);
      chk("u1_clk_periods", rise_c1 - b_rise, 8);
      chk("u1_finished", fin_c1 - b_fin, 1);
      chk("u1_cs", cserr1 - b_cs1, 0);
      chk("u1_rx_word", {24'd0, pout1}, {24'd0, LB ? 8'hC3 : 8'hFF});

      b_rise = rise_c1; b_fin = fin_c1; b_cs1 = cserr1;
      word1(8'h3C, 3'd5, 5'b11111);
      chk("oob_cs_high", cserr1 - b_cs1, 0);
      chk("oob_clk_periods", rise_c1 - b_rise, 8);
      chk("oob_finished", fin_c1 - b_fin, 1);
      chk("oob_bits", {24'd0, cap1[7:0]}, 32'h3C);
      chk("oob_rx_word", {24'd0, pout1}, {24'd0, LB ? 8'h3C : 8'hFF});
      chk("onehot_cs0", ohe0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
